// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm -- direct-mapped instruction cache between fetch and instruction
// memory.
//
// The tag compare is combinational on pc at the edge that accepts it, so a hit
// returns inst/valid one cycle after the fetch. A miss raises a line-aligned
// refill request on a valid/ready channel, takes WORDS_PER_LINE beats in
// ascending order, and forwards the requested word when the line completes.
//
// Parameters:
//   LINES          number of cache lines (power of 2, >= 2)
//   WORDS_PER_LINE 32-bit words per line (power of 2, >= 2)
//   ADDR_W         byte-address width of pc and of the memory port
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   pipeline_en     fetch stage advances; pc is sampled this edge
//   pc              fetch byte address (bits [1:0] ignored)
//   flush           invalidate all lines (fence.i)
//   inst, valid     registered instruction and its valid flag
//   mem_req_*       refill request channel (valid/ready, line address)
//   mem_resp_*      refill beats, ascending word order from the line base
//
// Optional feature, enabled by defining ICACHE_PERF_EN:
//   perf_hits, perf_misses  32-bit wrapping counters of accepted lookups
// -----------------------------------------------------------------------------
module icache_dm #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipeline_en,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic [31:0]       inst,
    output logic              valid,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {IDLE, LOOKUP, REQ, FILL} state_t;

    state_t state, state_next;

    logic [31:0]       data_mem [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  line_valid;

    logic [ADDR_W-1:0] miss_pc;
    logic [OFF_W-1:0]  beat_cnt;
    logic              flush_pending;

    // Address fields of the incoming pc and of the latched miss address.
    logic [OFF_W-1:0]  pc_off, miss_off;
    logic [IDX_W-1:0]  pc_idx, miss_idx;
    logic [TAG_W-1:0]  pc_tag, miss_tag;

    assign pc_off   = pc[OFF_W+1:2];
    assign pc_idx   = pc[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag   = pc[ADDR_W-1:IDX_W+OFF_W+2];
    assign miss_off = miss_pc[OFF_W+1:2];
    assign miss_idx = miss_pc[IDX_W+OFF_W+1:OFF_W+2];
    assign miss_tag = miss_pc[ADDR_W-1:IDX_W+OFF_W+2];

    // Byte-select bits never matter for 32-bit instruction fetch.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{pc[1:0], miss_pc[1:0]};

    logic accept, hit, last_beat;

    assign accept    = ((state == IDLE) || (state == LOOKUP)) && (pipeline_en || !valid);
    // A flush on the accepting edge clears the lines first, so the lookup misses.
    assign hit       = line_valid[pc_idx] && (tag_mem[pc_idx] == pc_tag) && !flush;
    assign last_beat = (state == FILL) && mem_resp_valid
                       && (beat_cnt == OFF_W'(WORDS_PER_LINE - 1));

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, LOOKUP: begin
                if (accept) state_next = hit ? LOOKUP : REQ;
                else        state_next = IDLE;
            end
            REQ:     if (mem_req_ready) state_next = FILL;
            FILL:    if (last_beat)     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst          <= '0;
            valid         <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            line_valid    <= '0;
            miss_pc       <= '0;
            beat_cnt      <= '0;
            flush_pending <= 1'b0;
`ifdef ICACHE_PERF_EN
            perf_hits     <= '0;
            perf_misses   <= '0;
`endif
        end else begin
            case (state)
                IDLE, LOOKUP: begin
                    if (flush) line_valid <= '0;
                    if (accept) begin
                        miss_pc <= pc;
                        if (hit) begin
                            inst  <= data_mem[pc_idx][pc_off];
                            valid <= 1'b1;
`ifdef ICACHE_PERF_EN
                            perf_hits <= perf_hits + 32'd1;
`endif
                        end else begin
                            valid         <= 1'b0;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {pc[ADDR_W-1:OFF_W+2], {(OFF_W+2){1'b0}}};
`ifdef ICACHE_PERF_EN
                            perf_misses <= perf_misses + 32'd1;
`endif
                        end
                    end
                end
                REQ: begin
                    if (flush) flush_pending <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat_cnt      <= '0;
                    end
                end
                FILL: begin
                    if (flush) flush_pending <= 1'b1;
                    if (mem_resp_valid) begin
                        beat_cnt <= beat_cnt + OFF_W'(1);
                        // Capture the requested word as it streams past.
                        if (beat_cnt == miss_off) inst <= mem_resp_data;
                        if (last_beat) begin
                            valid         <= 1'b1;
                            flush_pending <= 1'b0;
                            // A flush seen during the refill wins: the new line
                            // is written but not trusted.
                            if (flush_pending || flush) line_valid <= '0;
                            else                        line_valid[miss_idx] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the data and tag arrays are not reset; line_valid alone decides
    // whether their contents are trusted.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_resp_valid)
            data_mem[miss_idx][beat_cnt] <= mem_resp_data;
        if (last_beat)
            tag_mem[miss_idx] <= miss_tag;
    end

endmodule

// File: tb/tb_icache_dm.sv
// -----------------------------------------------------------------------------
// tb_icache_dm -- self-checking bench for icache_dm (default parameters).
// Expected instructions are pushed to a queue when a fetch is issued and
// popped when the cache reports valid. The memory content is a fixed function
// of the word address.
// -----------------------------------------------------------------------------
module tb_icache_dm;

    localparam int LINES = 64;
    localparam int WPL   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipeline_en;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] inst;
    logic        valid;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    icache_dm #(.LINES(LINES), .WORDS_PER_LINE(WPL), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipeline_en    (pipeline_en),
        .pc             (pc),
        .flush          (flush),
        .inst           (inst),
        .valid          (valid),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory image: word address XOR 0xE0, so line 0x100 holds 0xA0..0xA3.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ 32'h0000_00E0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present a fetch; its expected instruction joins the scoreboard.
    task automatic issue(input logic [31:0] a);
        pc          = a;
        pipeline_en = 1'b1;
        exp_q.push_back(mem_word(a));
    endtask

    // Wait (bounded) for valid, then compare inst with the oldest expectation.
    task automatic collect(input string tag, input int budget);
        logic [31:0] exp;
        for (int n = 0; n < budget && valid !== 1'b1; n++) step();
        check({tag, "_valid"}, {31'd0, valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_inst"}, inst, exp);
        end
    endtask

    // Called on the negedge after a missing fetch was accepted. Holds ready low
    // for ready_wait cycles with stray beats present, then returns the line,
    // optionally raising flush together with beat flush_beat.
    task automatic serve_miss(input string tag, input logic [31:0] line_addr,
                              input int ready_wait, input int flush_beat);
        pipeline_en = 1'b0;
        flush       = 1'b0;
        check({tag, "_miss_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_req_valid"}, {31'd0, mem_req_valid}, 32'd1);
        check({tag, "_req_addr"}, mem_req_addr, line_addr);
        for (int w = 0; w < ready_wait; w++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_BEEF;
            step();
            check({tag, "_hold_valid"}, {31'd0, mem_req_valid}, 32'd1);
            check({tag, "_hold_addr"}, mem_req_addr, line_addr);
        end
        mem_req_ready  = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        check({tag, "_req_drop"}, {31'd0, mem_req_valid}, 32'd0);
        for (int i = 0; i < WPL; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(line_addr + 32'(4 * i));
            flush          = (i == flush_beat);
            step();
            mem_resp_valid = 1'b0;
            flush          = 1'b0;
            if (i < WPL - 1) check({tag, "_fill_valid"}, {31'd0, valid}, 32'd0);
            if (i == 1) step();  // idle gap between beats
        end
        collect(tag, 4);
    endtask

    initial begin
        rst_n          = 1'b0;
        pipeline_en    = 1'b0;
        pc             = 32'h100;
        flush          = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        repeat (3) step();

        // Reset values.
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_req_addr", mem_req_addr, 32'd0);

        // First fetch misses and refills line 0x100.
        issue(32'h100);
        rst_n = 1'b1;
        step();
        serve_miss("first", 32'h100, 0, -1);

        // Back-to-back hits on the rest of the line.
        for (int k = 1; k < WPL; k++) begin
            issue(32'h100 + 32'(4 * k));
            step();
            collect("stream", 0);
            check("stream_no_req", {31'd0, mem_req_valid}, 32'd0);
        end

        // Conflict: same index, different tag, with a slow memory.
        issue(32'h100);
        step();
        collect("rehit", 0);
        issue(32'h100 + LINES * 16);
        step();
        serve_miss("conflict", 32'h100 + LINES * 16, 5, -1);
        issue(32'h100);
        step();
        serve_miss("evicted", 32'h100, 0, -1);

        // Flush on the accepting edge forces a miss on a resident line.
        issue(32'h104);
        flush = 1'b1;
        step();
        serve_miss("flush_idle", 32'h100, 0, -1);

        // Flush during the second refill beat: word still delivered, line not kept.
        issue(32'h208);
        step();
        serve_miss("flush_fill", 32'h200, 0, 1);
        issue(32'h200);
        step();
        serve_miss("after_flush", 32'h200, 0, -1);
        issue(32'h10C);
        step();
        serve_miss("other_flushed", 32'h100, 0, -1);

        // Reset in the middle of a refill, stray beats afterwards.
        issue(32'h304);
        step();
        pipeline_en   = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(32'h300 + 32'(4 * i));
            step();
        end
        rst_n = 1'b0;
        pc    = 32'h100;
        exp_q.delete();
        #1;
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_inst", inst, 32'd0);
        check("midrst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("midrst_req_addr", mem_req_addr, 32'd0);
        mem_resp_data = 32'hBAD0_BAD0;
        step();
        step();
        issue(32'h100);
        pipeline_en = 1'b0;
        rst_n = 1'b1;
        step();
        mem_resp_valid = 1'b0;
        serve_miss("post_rst", 32'h100, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
